// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: the arbiter FSM
// state encoding and the Wishbone bus widths.
package wb_arb_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_arbiter_2m1s.sv
// Two-master, one-slave pipelined Wishbone arbiter.  Ownership is granted
// per cyc frame, outstanding requests are counted so that only responses
// that belong to the current owner are forwarded, and stale slave acks
// (held while cyc is low) are dropped.
module wb_arbiter_2m1s
  import wb_arb_pkg::*;
#(
  parameter int PRIORITY_MODE   = 0,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_WIDTH       = 3
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             m0_wb_cyc_i,
  input  logic             m0_wb_stb_i,
  input  logic             m0_wb_we_i,
  input  logic [ADR_W-1:0] m0_wb_adr_i,
  input  logic [DAT_W-1:0] m0_wb_dat_i,
  input  logic [SEL_W-1:0] m0_wb_sel_i,
  output logic             m0_wb_stall_o,
  output logic             m0_wb_ack_o,
  output logic             m0_wb_err_o,
  output logic [DAT_W-1:0] m0_wb_dat_o,
  input  logic             m1_wb_cyc_i,
  input  logic             m1_wb_stb_i,
  input  logic             m1_wb_we_i,
  input  logic [ADR_W-1:0] m1_wb_adr_i,
  input  logic [DAT_W-1:0] m1_wb_dat_i,
  input  logic [SEL_W-1:0] m1_wb_sel_i,
  output logic             m1_wb_stall_o,
  output logic             m1_wb_ack_o,
  output logic             m1_wb_err_o,
  output logic [DAT_W-1:0] m1_wb_dat_o,
  output logic             s_wb_cyc_o,
  output logic             s_wb_stb_o,
  output logic             s_wb_we_o,
  output logic [ADR_W-1:0] s_wb_adr_o,
  output logic [DAT_W-1:0] s_wb_dat_o,
  output logic [SEL_W-1:0] s_wb_sel_o,
  input  logic             s_wb_stall_i,
  input  logic             s_wb_ack_i,
  input  logic             s_wb_err_i,
  input  logic [DAT_W-1:0] s_wb_dat_i
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

  arb_state_t           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 last_owner_q, last_owner_d;

  logic                 owned;
  logic                 own_sel;
  logic                 own_cyc, own_stb, own_we;
  logic [ADR_W-1:0]     own_adr;
  logic [DAT_W-1:0]     own_dat;
  logic [SEL_W-1:0]     own_sel_bytes;
  logic                 cnt_full;
  logic                 accept;
  logic                 resp;

  // Select the owning master's request and drive the slave and master sides
  always_comb begin
    owned         = (state_q != IDLE);
    own_sel       = (state_q == OWN1);
    own_cyc       = own_sel ? m1_wb_cyc_i : m0_wb_cyc_i;
    own_stb       = own_sel ? m1_wb_stb_i : m0_wb_stb_i;
    own_we        = own_sel ? m1_wb_we_i  : m0_wb_we_i;
    own_adr       = own_sel ? m1_wb_adr_i : m0_wb_adr_i;
    own_dat       = own_sel ? m1_wb_dat_i : m0_wb_dat_i;
    own_sel_bytes = own_sel ? m1_wb_sel_i : m0_wb_sel_i;
    cnt_full      = (cnt_q == CNT_MAX);

    s_wb_cyc_o = owned & own_cyc;
    s_wb_stb_o = owned & own_stb & (cnt_q < CNT_MAX);
    s_wb_we_o  = owned & own_we;
    s_wb_adr_o = owned ? own_adr       : '0;
    s_wb_dat_o = owned ? own_dat       : '0;
    s_wb_sel_o = owned ? own_sel_bytes : '0;

    accept = s_wb_stb_o & ~s_wb_stall_i;
    // A response only counts while something is outstanding; anything else
    // is a held-over ack from an earlier, already released frame.
    resp   = owned & (s_wb_ack_i | s_wb_err_i) & (cnt_q != '0) & ~wb_rst_i;

    m0_wb_stall_o = (state_q != OWN0) | s_wb_stall_i | cnt_full;
    m1_wb_stall_o = (state_q != OWN1) | s_wb_stall_i | cnt_full;
    m0_wb_ack_o   = (state_q == OWN0) & resp & s_wb_ack_i;
    m1_wb_ack_o   = (state_q == OWN1) & resp & s_wb_ack_i;
    m0_wb_err_o   = (state_q == OWN0) & resp & s_wb_err_i;
    m1_wb_err_o   = (state_q == OWN1) & resp & s_wb_err_i;
    m0_wb_dat_o   = s_wb_dat_i;
    m1_wb_dat_o   = s_wb_dat_i;
  end

  // Grant, release and outstanding-count bookkeeping
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_d = ((PRIORITY_MODE != 0) || last_owner_q) ? OWN0 : OWN1;
        end else if (m0_wb_cyc_i) begin
          state_d = OWN0;
        end else if (m1_wb_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!own_cyc) begin
          // Release (possibly an abort): forget anything still in flight
          state_d      = IDLE;
          cnt_d        = '0;
          last_owner_d = own_sel;
        end else if (accept && !resp) begin
          cnt_d = cnt_q + 1'b1;
        end else if (resp && !accept) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule
